lsu: RTL and testbench
======================

Name: lsu

Overview:
- Load/store unit directly downstream of the datapath.
- Consumes the datapath's aluout (address) and writedata, and returns readdata.
- Drives a req/ack handshake to a variable-latency data memory, with byte-lane enables and sub-word load extraction.
- Stalls the datapath (drives pc_enable low) until each access completes, and reports misaligned, illegal and timed-out accesses.

Parameters:
- n, 32, data/address width; only 32 is supported (4 byte lanes).
- TIMEOUT, 16, maximum REQ cycles to wait for mem_ack before aborting (>=1).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- memread  input  1  load request from controller
- memwrite  input  1  store request from controller
- size  input  2  00 byte, 01 half, 10 word, 11 reserved
- ld_unsigned  input  1  1 = zero-extend sub-word loads, 0 = sign-extend
- addr  input  n  byte address (datapath aluout)
- wdata  input  n  store data (datapath writedata); low bytes used for sub-word stores
- readdata  output  n  formatted load result to datapath
- pc_enable  output  1  0 = hold PC / stall the datapath
- mem_req  output  1  memory request, registered
- mem_we  output  1  1 = write
- mem_addr  output  n  word-aligned address ({addr[n-1:2],2'b00})
- mem_wdata  output  n  lane-replicated store data
- mem_be  output  4  byte enables; bit k = byte at addr[1:0]==k (little-endian)
- mem_ack  input  1  memory completion, one-cycle pulse
- mem_rdata  input  n  read data, valid with mem_ack
- fault  output  2  sticky fault code: 00 none, 01 misalign, 10 timeout, 11 illegal
- fault_addr  output  n  addr of the first faulting access

Behaviour:
- Reset (async, reset==0): state IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0, readdata=0, fault=00, fault_addr=0, timeout counter=0. pc_enable=1 during reset.
- Reset asserted mid-access drops mem_req immediately; a late mem_ack after reset release is ignored in IDLE.
- States: IDLE, REQ, DONE.
- IDLE
  - No access (memread=memwrite=0): pc_enable=1; stay IDLE.
  - memread & memwrite, or size==11: illegal. No memory access; pc_enable=1; readdata=0; fault/fault_addr set if fault==00; stay IDLE.
  - Misaligned (half with addr[0]=1; word with addr[1:0]!=0): same handling as illegal, code 01.
  - Legal access: pc_enable=0 combinationally this cycle. Capture addr, wdata, size, ld_unsigned and we=memwrite. Clear counter; next state REQ.
- REQ
  - mem_req=1; mem_we, mem_addr, mem_be, mem_wdata held stable; pc_enable=0.
  - Byte: be=1<<addr[1:0], wdata byte replicated x4. Half: be=4'b0011 or 4'b1100, halfword replicated x2. Word: be=4'b1111.
  - On mem_ack: load -> readdata = mem_rdata shifted right by 8*addr[1:0] then sign/zero-extended per size; store -> readdata unchanged. Next state DONE.
  - No ack: counter++. If counter reaches TIMEOUT-1 without ack: readdata=0; fault=10 if fault==00; next state DONE.
  - mem_req deasserts on entering DONE.
- DONE
  - pc_enable=1 for exactly one cycle; readdata valid.
  - The datapath commits the instruction (register write, PC update) on this edge.
  - Next state IDLE, which then samples the next instruction's controls.
- Minimum access time: 3 cycles (IDLE stall, REQ with same-cycle ack, DONE).
- mem_ack outside REQ is ignored.
- Datapath register writes during stall cycles are overwritten by the DONE-cycle write; this is accepted.
- fault stays sticky until reset; only the first fault is recorded.

Decomposition:
- Package lsu_pkg: size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), state enum, fault codes (F_NONE/F_MISALIGN/F_TIMEOUT/F_ILLEGAL), LANES=4.
- One combinational sub-module lsu_align: given size, addr[1:0] and raw store data, produces be and mem_wdata; given mem_rdata, size, addr[1:0] and ld_unsigned, produces the extracted load value.
- The FSM and timeout counter stay in lsu.

Test Plan:
- Word load addr=0x100, ack on 2nd REQ cycle with mem_rdata=0xDEADBEEF -> mem_be=1111, mem_addr=0x100, pc_enable low 3 cycles then high 1 cycle, readdata=0xDEADBEEF.
- Byte load addr=0x103, signed, mem_rdata=0x80FF_0000 -> be=1000, readdata=0xFFFFFF80; same access with ld_unsigned=1 -> 0x00000080.
- Half store addr=0x202, wdata=0x1234ABCD -> mem_we=1, be=1100, mem_wdata=0xABCDABCD, mem_addr=0x200.
- Word load addr=0x105 -> no mem_req, pc_enable stays 1, fault=01, fault_addr=0x105; a later timeout leaves fault=01.
- No ack for TIMEOUT=16 cycles -> mem_req drops after 16 REQ cycles, readdata=0, fault=10, DONE pulse on pc_enable.
- Reset pulled low during REQ -> mem_req=0 immediately, fault=00; a stray mem_ack after release causes no change.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states, fault codes
// and the alignment rule used when a request is decoded.
package lsu_pkg;

  localparam int LANES = 4;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    F_NONE     = 2'b00,
    F_MISALIGN = 2'b01,
    F_TIMEOUT  = 2'b10,
    F_ILLEGAL  = 2'b11
  } fault_e;

  // Natural alignment: halves on even bytes, words on 4-byte boundaries.
  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] lo);
    logic mis;
    case (sz)
      SZ_HALF: mis = lo[0];
      SZ_WORD: mis = (lo != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store byte enables and lane replication, and load-data
// extraction with sign or zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]           size,
  input  logic [1:0]           lo,
  input  logic [LANES*8-1:0]   wdata,
  input  logic [LANES*8-1:0]   rdata,
  input  logic                 ld_unsigned,
  output logic [LANES-1:0]     be,
  output logic [LANES*8-1:0]   wdata_rep,
  output logic [LANES*8-1:0]   ldval
);

  logic [LANES*8-1:0] shifted_s;
  logic               sext_s;

  // Lane selection and extension for the requested access size.
  always_comb begin
    shifted_s = rdata >> {lo, 3'b000};
    be        = 4'b0000;
    wdata_rep = 32'h0000_0000;
    ldval     = 32'h0000_0000;
    sext_s    = 1'b0;
    case (size)
      SZ_BYTE: begin
        be        = 4'b0001 << lo;
        wdata_rep = {4{wdata[7:0]}};
        sext_s    = ~ld_unsigned & shifted_s[7];
        ldval     = {{24{sext_s}}, shifted_s[7:0]};
      end
      SZ_HALF: begin
        be        = lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        sext_s    = ~ld_unsigned & shifted_s[15];
        ldval     = {{16{sext_s}}, shifted_s[15:0]};
      end
      SZ_WORD: begin
        be        = 4'b1111;
        wdata_rep = wdata;
        ldval     = shifted_s;
      end
      default: begin
        be        = 4'b0000;
        wdata_rep = 32'h0000_0000;
        ldval     = 32'h0000_0000;
      end
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: decodes datapath memory controls, runs a req/ack access to a
// variable-latency memory, stalls the PC meanwhile and records the first fault.
module lsu
  import lsu_pkg::*;
#(
  parameter int n       = 32,
  parameter int TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         memread,
  input  logic         memwrite,
  input  logic [1:0]   size,
  input  logic         ld_unsigned,
  input  logic [n-1:0] addr,
  input  logic [n-1:0] wdata,
  output logic [n-1:0] readdata,
  output logic         pc_enable,
  output logic         mem_req,
  output logic         mem_we,
  output logic [n-1:0] mem_addr,
  output logic [n-1:0] mem_wdata,
  output logic [3:0]   mem_be,
  input  logic         mem_ack,
  input  logic [n-1:0] mem_rdata,
  output logic [1:0]   fault,
  output logic [n-1:0] fault_addr
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_e          state_r;
  logic [CW-1:0]   cnt_r;
  logic [n-1:0]    addr_r;
  logic [1:0]      size_r;
  logic            uns_r;
  logic            we_r;
  logic            mem_req_r;
  logic            mem_we_r;
  logic [n-1:0]    mem_addr_r;
  logic [n-1:0]    mem_wdata_r;
  logic [3:0]      mem_be_r;
  logic [n-1:0]    readdata_r;
  logic [1:0]      fault_r;
  logic [n-1:0]    fault_addr_r;

  logic            access_s;
  logic            illegal_s;
  logic            misalign_s;
  logic            legal_s;
  logic [1:0]      bad_code_s;
  logic            in_idle_s;
  logic [1:0]      sel_size_s;
  logic [1:0]      sel_lo_s;
  logic            sel_uns_s;
  logic [3:0]      be_s;
  logic [n-1:0]    wdata_rep_s;
  logic [n-1:0]    ldval_s;
  logic            pc_enable_s;

  assign access_s   = memread | memwrite;
  assign illegal_s  = access_s & ((memread & memwrite) | (size == SZ_RSVD));
  assign misalign_s = access_s & ~illegal_s & is_misaligned(size, addr[1:0]);
  assign legal_s    = access_s & ~illegal_s & ~misalign_s;
  assign bad_code_s = illegal_s ? F_ILLEGAL : F_MISALIGN;

  // While idle the lanes follow the live request; afterwards the captured one.
  assign in_idle_s  = (state_r == ST_IDLE);
  assign sel_size_s = in_idle_s ? size        : size_r;
  assign sel_lo_s   = in_idle_s ? addr[1:0]   : addr_r[1:0];
  assign sel_uns_s  = in_idle_s ? ld_unsigned : uns_r;

  lsu_align u_align (
    .size        (sel_size_s),
    .lo          (sel_lo_s),
    .wdata       (wdata),
    .rdata       (mem_rdata),
    .ld_unsigned (sel_uns_s),
    .be          (be_s),
    .wdata_rep   (wdata_rep_s),
    .ldval       (ldval_s)
  );

  // Stall decision: the stall must start in the same cycle a legal access is seen.
  always_comb begin
    pc_enable_s = 1'b1;
    if (!reset) begin
      pc_enable_s = 1'b1;
    end else if (state_r == ST_REQ) begin
      pc_enable_s = 1'b0;
    end else if (in_idle_s && legal_s) begin
      pc_enable_s = 1'b0;
    end else begin
      pc_enable_s = 1'b1;
    end
  end

  // Access FSM with timeout counter, bus registers, load result and sticky fault.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      cnt_r        <= '0;
      addr_r       <= '0;
      size_r       <= 2'b00;
      uns_r        <= 1'b0;
      we_r         <= 1'b0;
      mem_req_r    <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= '0;
      mem_wdata_r  <= '0;
      mem_be_r     <= 4'b0000;
      readdata_r   <= '0;
      fault_r      <= F_NONE;
      fault_addr_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (legal_s) begin
            addr_r      <= addr;
            size_r      <= size;
            uns_r       <= ld_unsigned;
            we_r        <= memwrite;
            cnt_r       <= '0;
            mem_req_r   <= 1'b1;
            mem_we_r    <= memwrite;
            mem_addr_r  <= {addr[n-1:2], 2'b00};
            mem_be_r    <= be_s;
            mem_wdata_r <= wdata_rep_s;
            state_r     <= ST_REQ;
          end else if (illegal_s || misalign_s) begin
            readdata_r <= '0;
            if (fault_r == F_NONE) begin
              fault_r      <= bad_code_s;
              fault_addr_r <= addr;
            end
          end
        end
        ST_REQ: begin
          if (mem_ack) begin
            if (!we_r) begin
              readdata_r <= ldval_s;
            end
            mem_req_r <= 1'b0;
            state_r   <= ST_DONE;
          end else if (cnt_r == CW'(TIMEOUT - 1)) begin
            readdata_r <= '0;
            if (fault_r == F_NONE) begin
              fault_r      <= F_TIMEOUT;
              fault_addr_r <= addr_r;
            end
            mem_req_r <= 1'b0;
            state_r   <= ST_DONE;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          mem_req_r <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

  assign readdata   = readdata_r;
  assign pc_enable  = pc_enable_s;
  assign mem_req    = mem_req_r;
  assign mem_we     = mem_we_r;
  assign mem_addr   = mem_addr_r;
  assign mem_wdata  = mem_wdata_r;
  assign mem_be     = mem_be_r;
  assign fault      = fault_r;
  assign fault_addr = fault_addr_r;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed vector table, hand-written reset sequence,
// and randomized accesses scored against an arithmetic reference model.
module tb_lsu;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        memread = 1'b0;
  logic        memwrite = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        ld_unsigned = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] readdata;
  logic        pc_enable;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic [1:0]  fault;
  logic [31:0] fault_addr;

  int n_cmp = 0;
  int n_bad = 0;

  lsu #(.n(32), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .memread(memread), .memwrite(memwrite),
    .size(size), .ld_unsigned(ld_unsigned), .addr(addr), .wdata(wdata),
    .readdata(readdata), .pc_enable(pc_enable), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .fault(fault), .fault_addr(fault_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          mr;
    bit          mw;
    logic [1:0]  sz;
    bit          uns;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    int          dly;
    int          e_stall;
    int          e_req;
    logic [31:0] e_rd;
    logic [3:0]  e_be;
    logic [31:0] e_ma;
    logic [31:0] e_mwd;
    logic [1:0]  e_fault;
    logic [31:0] e_fa;
  } vec_t;

  vec_t tbl[10];

  // Results of the most recent access, filled in by run_access.
  int          r_stall, r_req;
  logic [31:0] r_rd, r_ma, r_mwd;
  logic [3:0]  r_be;
  logic        r_we;
  bit          r_stable, r_done;

  // Drive one instruction; ack arrives in REQ cycle number dly (0-based).
  task automatic run_access(input bit mr, input bit mw, input logic [1:0] sz, input bit uns,
                            input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] rdv, input int dly);
    memread = mr; memwrite = mw; size = sz; ld_unsigned = uns; addr = a; wdata = wd;
    r_stall = 0; r_req = 0; r_stable = 1'b1; r_done = 1'b0;
    r_be = 4'h0; r_ma = 32'h0; r_mwd = 32'h0; r_we = 1'b0;
    @(negedge clk);
    if (!pc_enable) r_stall++;
    if (mem_req) r_req++;
    @(posedge clk); #1;
    memread = 1'b0; memwrite = 1'b0; addr = $urandom; wdata = $urandom;
    if (r_stall != 0) begin
      for (int k = 0; k < 40; k++) begin
        if (k == dly) begin mem_ack = 1'b1; mem_rdata = rdv; end
        else begin mem_ack = 1'b0; mem_rdata = $urandom; end
        @(negedge clk);
        if (pc_enable) begin r_done = 1'b1; break; end
        r_stall++;
        if (mem_req) begin
          if (r_req == 0) begin
            r_be = mem_be; r_ma = mem_addr; r_mwd = mem_wdata; r_we = mem_we;
          end else if (mem_be !== r_be || mem_addr !== r_ma || mem_wdata !== r_mwd || mem_we !== r_we) begin
            r_stable = 1'b0;
          end
          r_req++;
        end
        @(posedge clk); #1;
        mem_ack = 1'b0;
      end
      mem_ack = 1'b0;
      r_rd = readdata;
      @(posedge clk); #1;
    end else begin
      r_done = 1'b1;
      r_rd = readdata;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0; memread = 1'b1; size = 2'b10; addr = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc_enable", {31'h0, pc_enable}, 32'h1);
    chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
    chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_mem_be", {28'h0, mem_be}, 32'h0);
    chk("rst_readdata", readdata, 32'h0);
    chk("rst_fault", {30'h0, fault}, 32'h0);
    chk("rst_fault_addr", fault_addr, 32'h0);
    memread = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  // Reference load formatting: shift to lane 0, mask to size, extend the top bit.
  function automatic logic [31:0] ref_load(input logic [1:0] sz, input bit uns,
                                           input logic [31:0] a, input logic [31:0] rdv);
    logic [31:0] v, mask, top;
    int nb, lo;
    nb = 1 << sz; lo = int'(a % 4);
    v = rdv >> (8 * lo);
    mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 32'h1);
    v = v & mask;
    top = (mask >> 1) + 32'h1;
    if (!uns && ((v & top) != 32'h0)) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] r;
    case (sz)
      2'b00:   r = (wd & 32'hFF) * 32'h0101_0101;
      2'b01:   r = (wd & 32'hFFFF) * 32'h0001_0001;
      default: r = wd;
    endcase
    return r;
  endfunction

  bit          g_mr, g_mw, g_ill, g_mis, g_acc, g_to;
  logic [1:0]  g_sz;
  bit          g_uns;
  logic [31:0] g_a, g_wd, g_rdv, m_rd, m_fa, e_mwd;
  logic [1:0]  m_fault;
  logic [3:0]  e_be;
  int          g_dly, g_nb, g_sel, e_req, e_stall;

  initial begin
    //        mr mw sz     uns a             wd            rd            dly stall req e_rd          be     ma            mwd           flt    fa
    tbl[0] = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 1, 3, 2, 32'hDEAD_BEEF, 4'b1111, 32'h0000_0100, 32'h0, 2'b00, 32'h0};
    tbl[1] = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0, 32'h80FF_0000, 0, 2, 1, 32'hFFFF_FF80, 4'b1000, 32'h0000_0100, 32'h0, 2'b00, 32'h0};
    tbl[2] = '{1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0, 32'h80FF_0000, 0, 2, 1, 32'h0000_0080, 4'b1000, 32'h0000_0100, 32'h0, 2'b00, 32'h0};
    tbl[3] = '{1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h1234_ABCD, 32'h0, 2, 4, 3, 32'h0000_0080, 4'b1100, 32'h0000_0200, 32'hABCD_ABCD, 2'b00, 32'h0};
    tbl[4] = '{1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0102, 32'h0, 32'h8001_7FFF, 0, 2, 1, 32'hFFFF_8001, 4'b1100, 32'h0000_0100, 32'h0, 2'b00, 32'h0};
    tbl[5] = '{1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0101, 32'h0000_00A5, 32'h0, 0, 2, 1, 32'hFFFF_8001, 4'b0010, 32'h0000_0100, 32'hA5A5_A5A5, 2'b00, 32'h0};
    tbl[6] = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0105, 32'h0, 32'h0, 0, 0, 0, 32'h0, 4'b0000, 32'h0, 32'h0, 2'b01, 32'h0000_0105};
    tbl[7] = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'h0, 32'h0, 99, 17, 16, 32'h0, 4'b1111, 32'h0000_0300, 32'h0, 2'b01, 32'h0000_0105};
    tbl[8] = '{1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_0400, 32'h0, 32'h0, 0, 0, 0, 32'h0, 4'b0000, 32'h0, 32'h0, 2'b01, 32'h0000_0105};
    tbl[9] = '{1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_03FF, 32'h0, 32'h7F00_0000, 3, 5, 4, 32'h0000_007F, 4'b1000, 32'h0000_03FC, 32'h0, 2'b01, 32'h0000_0105};

    do_reset();

    for (int i = 0; i < 10; i++) begin
      run_access(tbl[i].mr, tbl[i].mw, tbl[i].sz, tbl[i].uns, tbl[i].a, tbl[i].wd, tbl[i].rd, tbl[i].dly);
      chk($sformatf("v%0d_done", i), {31'h0, r_done}, 32'h1);
      chk($sformatf("v%0d_stall", i), r_stall, tbl[i].e_stall);
      chk($sformatf("v%0d_req", i), r_req, tbl[i].e_req);
      chk($sformatf("v%0d_readdata", i), r_rd, tbl[i].e_rd);
      chk($sformatf("v%0d_fault", i), {30'h0, fault}, {30'h0, tbl[i].e_fault});
      chk($sformatf("v%0d_fault_addr", i), fault_addr, tbl[i].e_fa);
      if (tbl[i].e_req > 0) begin
        chk($sformatf("v%0d_be", i), {28'h0, r_be}, {28'h0, tbl[i].e_be});
        chk($sformatf("v%0d_addr", i), r_ma, tbl[i].e_ma);
        chk($sformatf("v%0d_we", i), {31'h0, r_we}, {31'h0, tbl[i].mw});
        chk($sformatf("v%0d_stable", i), {31'h0, r_stable}, 32'h1);
        if (tbl[i].mw) chk($sformatf("v%0d_wdata", i), r_mwd, tbl[i].e_mwd);
      end
    end

    // Reset pulled during REQ, then a stray ack after release.
    memread = 1'b1; memwrite = 1'b0; size = 2'b10; addr = 32'h0000_0400; mem_ack = 1'b0;
    @(posedge clk); #1;
    memread = 1'b0;
    @(negedge clk);
    chk("rq_mem_req_before", {31'h0, mem_req}, 32'h1);
    #2 reset = 1'b0;
    #1;
    chk("rq_mem_req_async", {31'h0, mem_req}, 32'h0);
    chk("rq_pc_enable", {31'h0, pc_enable}, 32'h1);
    chk("rq_fault", {30'h0, fault}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    chk("rq_stray_req", {31'h0, mem_req}, 32'h0);
    chk("rq_stray_pc", {31'h0, pc_enable}, 32'h1);
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(negedge clk);
    chk("rq_stray_readdata", readdata, 32'h0);
    chk("rq_stray_fault", {30'h0, fault}, 32'h0);
    chk("rq_stray_req2", {31'h0, mem_req}, 32'h0);
    @(posedge clk); #1;

    // Randomized accesses against the reference model.
    do_reset();
    m_rd = 32'h0; m_fault = 2'b00; m_fa = 32'h0;
    for (int i = 0; i < 300; i++) begin
      g_sel = $urandom_range(0, 15);
      g_mr = (g_sel == 1) || (g_sel >= 2 && g_sel < 9);
      g_mw = (g_sel == 1) || (g_sel >= 9);
      g_sel = $urandom_range(0, 9);
      g_sz = (g_sel < 3) ? 2'b00 : (g_sel < 6) ? 2'b01 : (g_sel < 9) ? 2'b10 : 2'b11;
      g_uns = $urandom_range(0, 1) == 1;
      g_a = $urandom;
      if ($urandom_range(0, 1) == 1) g_a = g_a - (g_a % (32'h1 << g_sz));
      g_wd = $urandom; g_rdv = $urandom;
      g_dly = ($urandom_range(0, 39) == 0) ? 99 : $urandom_range(0, 5);

      g_acc = g_mr || g_mw;
      g_nb = 1 << g_sz;
      g_ill = g_acc && ((g_mr && g_mw) || g_sz == 2'b11);
      g_mis = g_acc && !g_ill && ((g_a % g_nb) != 0);
      g_to = g_dly >= 16;
      e_req = 0; e_stall = 0; e_be = 4'h0; e_mwd = 32'h0;
      if (g_ill || g_mis) begin
        m_rd = 32'h0;
        if (m_fault == 2'b00) begin m_fault = g_ill ? 2'b11 : 2'b01; m_fa = g_a; end
      end else if (g_acc) begin
        e_req = g_to ? 16 : g_dly + 1;
        e_stall = e_req + 1;
        e_be = 4'(((1 << g_nb) - 1) << (g_a % 4));
        e_mwd = ref_wdata(g_sz, g_wd);
        if (g_to) begin
          m_rd = 32'h0;
          if (m_fault == 2'b00) begin m_fault = 2'b10; m_fa = g_a; end
        end else if (g_mr) begin
          m_rd = ref_load(g_sz, g_uns, g_a, g_rdv);
        end
      end

      run_access(g_mr, g_mw, g_sz, g_uns, g_a, g_wd, g_rdv, g_dly);
      chk($sformatf("r%0d_done", i), {31'h0, r_done}, 32'h1);
      chk($sformatf("r%0d_stall", i), r_stall, e_stall);
      chk($sformatf("r%0d_req", i), r_req, e_req);
      chk($sformatf("r%0d_readdata", i), r_rd, m_rd);
      chk($sformatf("r%0d_fault", i), {30'h0, fault}, {30'h0, m_fault});
      chk($sformatf("r%0d_fault_addr", i), fault_addr, m_fa);
      if (e_req > 0) begin
        chk($sformatf("r%0d_be", i), {28'h0, r_be}, {28'h0, e_be});
        chk($sformatf("r%0d_addr", i), r_ma, g_a & 32'hFFFF_FFFC);
        chk($sformatf("r%0d_we", i), {31'h0, r_we}, {31'h0, g_mw});
        chk($sformatf("r%0d_stable", i), {31'h0, r_stable}, 32'h1);
        if (g_mw) chk($sformatf("r%0d_wdata", i), r_mwd, e_mwd);
      end
      if ($urandom_range(0, 63) == 0) begin
        do_reset();
        m_rd = 32'h0; m_fault = 2'b00; m_fa = 32'h0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
